// File: rtl/axis_tag_mux_pkg.sv
// Shared types and the round-robin selector for axis_tag_mux.
package axis_tag_mux_pkg;

  typedef enum logic {StIdle, StActive} state_e;

  localparam int unsigned MaxPorts = 32;
  localparam int unsigned PortIdxW = 5;

  typedef struct packed {
    logic                valid;
    logic [PortIdxW-1:0] idx;
  } rr_sel_t;

  // First requesting port scanning upward from last_grant+1, wrapping at n_ports.
  function automatic rr_sel_t rr_select(input logic [MaxPorts-1:0] req,
                                        input int unsigned n_ports,
                                        input int unsigned last_grant);
    rr_sel_t     sel;
    int unsigned p;
    sel = '0;
    for (int unsigned i = 1; i <= MaxPorts; i++) begin
      p = last_grant + i;
      if (p >= n_ports) p = p - n_ports;
      if (i <= n_ports && !sel.valid && req[p[PortIdxW-1:0]]) begin
        sel.valid = 1'b1;
        sel.idx   = p[PortIdxW-1:0];
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/axis_skid_async.sv
// Two-entry skid buffer; in_ready is a pure register output so upstream sees no
// combinational path from out_ready.
module axis_skid_async #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [Width-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic             main_valid_q, main_valid_d;
  logic             temp_valid_q, temp_valid_d;
  logic [Width-1:0] main_data_q, main_data_d;
  logic [Width-1:0] temp_data_q, temp_data_d;

  assign in_ready  = !temp_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;

  always_comb begin
    main_valid_d = main_valid_q;
    temp_valid_d = temp_valid_q;
    main_data_d  = main_data_q;
    temp_data_d  = temp_data_q;
    if (out_ready || !main_valid_q) begin
      if (temp_valid_q) begin
        // Drain the parked beat first to keep ordering.
        main_valid_d = 1'b1;
        main_data_d  = temp_data_q;
        temp_valid_d = 1'b0;
      end else begin
        main_valid_d = in_valid;
        if (in_valid) main_data_d = in_data;
      end
    end else if (in_valid && !temp_valid_q) begin
      temp_valid_d = 1'b1;
      temp_data_d  = in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      temp_valid_q <= 1'b0;
      main_data_q  <= '0;
      temp_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      temp_valid_q <= temp_valid_d;
      main_data_q  <= main_data_d;
      temp_data_q  <= temp_data_d;
    end
  end

endmodule

// File: rtl/axis_tag_mux.sv
// N-to-1 AXI4-Stream frame merger: round-robin, frame-locked grant; the source
// port index is carried out on m_axis_tdest.
module axis_tag_mux #(
  parameter int S_COUNT     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
  parameter int ID_ENABLE   = 0,
  parameter int ID_WIDTH    = 8,
  parameter int DEST_WIDTH  = $clog2(S_COUNT),
  parameter int USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  output logic [S_COUNT-1:0]            s_axis_tready,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  input  logic [S_COUNT*ID_WIDTH-1:0]   s_axis_tid,
  input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [ID_WIDTH-1:0]           m_axis_tid,
  output logic [DEST_WIDTH-1:0]         m_axis_tdest,
  output logic [USER_WIDTH-1:0]         m_axis_tuser
);
  import axis_tag_mux_pkg::*;

  localparam int GrantW   = $clog2(S_COUNT);
  localparam int PayloadW = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;

  state_e              state_q, state_d;
  logic [GrantW-1:0]   grant_q, grant_d;
  logic [GrantW-1:0]   last_grant_q, last_grant_d;
  rr_sel_t             rr_sel;
  logic                skid_ready;
  logic                beat_accept;
  logic                sel_valid, sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [KEEP_WIDTH-1:0] sel_keep;
  logic [ID_WIDTH-1:0]   sel_id;
  logic [USER_WIDTH-1:0] sel_user;
  logic [PayloadW-1:0]   in_payload, out_payload;

  // Disabled sidebands are forced here so they reach the output registers as constants.
  assign sel_valid = s_axis_tvalid[grant_q];
  assign sel_last  = s_axis_tlast[grant_q];
  assign sel_data  = s_axis_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
  assign sel_keep  = s_axis_tkeep[grant_q*KEEP_WIDTH +: KEEP_WIDTH]
                     | {KEEP_WIDTH{KEEP_ENABLE == 0}};
  assign sel_id    = s_axis_tid[grant_q*ID_WIDTH +: ID_WIDTH] & {ID_WIDTH{ID_ENABLE != 0}};
  assign sel_user  = s_axis_tuser[grant_q*USER_WIDTH +: USER_WIDTH]
                     & {USER_WIDTH{USER_ENABLE != 0}};

  assign beat_accept = (state_q == StActive) && sel_valid && skid_ready;
  assign in_payload  = {sel_data, sel_keep, sel_last, sel_id, DEST_WIDTH'(grant_q), sel_user};

  assign rr_sel = rr_select(MaxPorts'(s_axis_tvalid), S_COUNT, 32'(last_grant_q));

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    s_axis_tready = '0;
    unique case (state_q)
      StIdle: begin
        if (rr_sel.valid) begin
          for (int k = 0; k < S_COUNT; k++) begin
            if (rr_sel.idx == PortIdxW'(k)) grant_d = GrantW'(k);
          end
          state_d = StActive;
        end
      end
      StActive: begin
        s_axis_tready[grant_q] = skid_ready;
        if (beat_accept && sel_last) begin
          last_grant_d = grant_q;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= GrantW'(S_COUNT - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  axis_skid_async #(
    .Width(PayloadW)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_payload),
    .in_valid (beat_accept),
    .in_ready (skid_ready),
    .out_data (out_payload),
    .out_valid(m_axis_tvalid),
    .out_ready(m_axis_tready)
  );

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tdest, m_axis_tuser} =
      out_payload;

endmodule

// File: tb/tb_axis_tag_mux.sv
// Randomized bench for axis_tag_mux against a transaction-level model of the
// arbiter and the two-deep output buffer.
module tb_axis_tag_mux;

  localparam int S  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [S*8-1:0] s_axis_tdata = '0;
  logic [S-1:0]  s_axis_tkeep = '0;
  logic [S-1:0]  s_axis_tvalid = '0;
  logic [S-1:0]  s_axis_tready;
  logic [S-1:0]  s_axis_tlast = '0;
  logic [S*8-1:0] s_axis_tid = '0;
  logic [S-1:0]  s_axis_tuser = '0;
  logic [7:0]    m_axis_tdata;
  logic [0:0]    m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic [7:0]    m_axis_tid;
  logic [1:0]    m_axis_tdest;
  logic [0:0]    m_axis_tuser;

  always #5 clk = ~clk;

  axis_tag_mux #(
    .S_COUNT    (S),
    .DATA_WIDTH (DW),
    .KEEP_ENABLE(0),
    .KEEP_WIDTH (1),
    .ID_ENABLE  (0),
    .ID_WIDTH   (8),
    .DEST_WIDTH (2),
    .USER_ENABLE(1),
    .USER_WIDTH (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tid   (s_axis_tid),
    .s_axis_tuser (s_axis_tuser),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tid   (m_axis_tid),
    .m_axis_tdest (m_axis_tdest),
    .m_axis_tuser (m_axis_tuser)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [1:0] dest;
    logic       user;
  } beat_t;

  // Reference model state
  beat_t mq[$];
  bit    m_idle;
  int    m_grant, m_last;
  int    first_dest;

  // Source drivers
  int         pf_len[S], pf_idx[S];
  bit         pf_act[S];
  logic       dv[S], dl[S], du[S];
  logic [7:0] dd[S];
  bit         acc[S];
  int         frames_in[S], frames_out[S];
  int         mode;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [S-1:0] req, input int last);
    for (int k = 1; k <= S; k++) begin
      if (req[(last + k) % S]) return (last + k) % S;
    end
    return -1;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_idle     = 1'b1;
    m_grant    = 0;
    m_last     = S - 1;
    first_dest = -1;
  endtask

  // Called between edges: compare, then advance the model to the next edge.
  task automatic model_step();
    logic [S-1:0] exp_rdy;
    beat_t        b;
    int           k;
    exp_rdy = '0;
    if (!m_idle && mq.size() < 2) exp_rdy[m_grant] = 1'b1;
    check_val("s_tready", 32'(s_axis_tready), 32'(exp_rdy));
    check_val("m_tvalid", 32'(m_axis_tvalid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      b = {m_axis_tdata, m_axis_tlast, m_axis_tdest, m_axis_tuser};
      check_val("m_beat", 32'(b), 32'(mq[0]));
      check_val("m_keep_id", {23'd0, m_axis_tkeep, m_axis_tid}, {23'd0, 1'b1, 8'h00});
    end
    for (int p = 0; p < S; p++) acc[p] = s_axis_tvalid[p] && s_axis_tready[p];
    if (mq.size() > 0 && m_axis_tready) begin
      b = mq.pop_front();
      if (first_dest < 0) first_dest = int'(b.dest);
      if (b.last) frames_out[b.dest]++;
    end
    if (!m_idle) begin
      if (exp_rdy[m_grant] && s_axis_tvalid[m_grant]) begin
        b = {s_axis_tdata[m_grant*8 +: 8], s_axis_tlast[m_grant], 2'(m_grant),
             s_axis_tuser[m_grant]};
        mq.push_back(b);
        if (b.last) begin
          m_idle = 1'b1;
          m_last = m_grant;
        end
      end
    end else begin
      k = rr_pick(s_axis_tvalid, m_last);
      if (k >= 0) begin
        m_grant = k;
        m_idle  = 1'b0;
      end
    end
  endtask

  function automatic bit start_ok(input int p);
    case (mode)
      0:       return $urandom_range(0, 2) == 0;
      1:       return p == 3;
      3:       return p == 0 || p == 2;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive();
    for (int p = 0; p < S; p++) begin
      if (dv[p] && acc[p]) begin
        pf_idx[p]++;
        dv[p] = 1'b0;
        if (pf_idx[p] == pf_len[p]) begin
          pf_act[p] = 1'b0;
          frames_in[p]++;
        end
      end
      if (!dv[p]) begin
        if (!pf_act[p] && start_ok(p)) begin
          pf_act[p] = 1'b1;
          pf_len[p] = (mode == 1) ? 2 : int'($urandom_range(1, 4));
          pf_idx[p] = 0;
        end
        // Bubbles only mid-frame so the arbitration set is the set of waiting frames.
        if (pf_act[p] && (pf_idx[p] == 0 || mode != 0 || $urandom_range(0, 3) != 0)) begin
          dv[p] = 1'b1;
          dd[p] = 8'($urandom);
          dl[p] = (pf_idx[p] == pf_len[p] - 1);
          du[p] = 1'($urandom);
        end
      end
      s_axis_tvalid[p]       = dv[p];
      s_axis_tdata[p*8 +: 8] = dd[p];
      s_axis_tlast[p]        = dl[p];
      s_axis_tuser[p]        = du[p];
    end
    s_axis_tkeep  = 4'($urandom);
    s_axis_tid    = $urandom;
    m_axis_tready = (mode == 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  task automatic driver_reset();
    for (int p = 0; p < S; p++) begin
      pf_act[p] = 1'b0;
      pf_len[p] = 0;
      pf_idx[p] = 0;
      dv[p] = 1'b0; dl[p] = 1'b0; du[p] = 1'b0; dd[p] = 8'h00;
      acc[p] = 1'b0;
      frames_in[p] = 0;
      frames_out[p] = 0;
    end
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
  endtask

  task automatic run(input int n, input int md);
    mode = md;
    repeat (n) begin
      @(posedge clk);
      #1 drive();
      @(negedge clk);
      if (!rst) model_step();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_m_tvalid"}, 32'(m_axis_tvalid), 32'd0);
    check_val({tag, "_s_tready"}, 32'(s_axis_tready), 32'd0);
    check_val({tag, "_m_fields"},
              {8'd0, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tdest,
               m_axis_tuser}, 32'd0);
  endtask

  initial begin
    int guard;
    driver_reset();
    model_reset();
    mode = 2;
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;

    run(1500, 0);   // random traffic, random backpressure
    run(310, 1);    // port 3 back-to-back 2-beat frames
    run(60, 2);     // drain
    check_val("drain_empty", 32'(mq.size()), 32'd0);
    for (int p = 0; p < S; p++) check_val("frames_match", 32'(frames_out[p]), 32'(frames_in[p]));

    // Asynchronous reset in the middle of a frame.
    guard = 0;
    while (!(!m_idle && mq.size() > 0) && guard < 200) begin
      run(1, 0);
      guard++;
    end
    check_val("midframe_reached", 32'(guard < 200), 32'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    driver_reset();
    model_reset();
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    run(1, 3);      // ports 0 and 2 request together
    run(40, 2);
    check_val("first_after_rst", 32'(first_dest), 32'd0);
    check_val("post_rst_empty", 32'(mq.size()), 32'd0);
    for (int p = 0; p < S; p++) check_val("post_rst_frames", 32'(frames_out[p]), 32'(frames_in[p]));
    check_val("post_rst_p0", 32'(frames_out[0]), 32'd1);
    check_val("post_rst_p2", 32'(frames_out[2]), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
